// File: rtl/gb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_pkg
//  Description : Shared types and helpers for the banked global buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_pkg;

    localparam logic c_PRIO_INT = 1'b0;
    localparam logic c_PRIO_EXT = 1'b1;

    typedef struct packed {
        logic ext_grant;
        logic int_grant;
    } gb_grant_t;

    function automatic int unsigned bank_sel_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    // Two-requester fixed-priority arbiter for one bank port.
    function automatic gb_grant_t arbitrate(input logic ext_req,
                                            input logic int_req,
                                            input logic prio);
        gb_grant_t g;
        if (prio == c_PRIO_EXT) begin
            g.ext_grant = ext_req;
            g.int_grant = int_req & ~ext_req;
        end else begin
            g.int_grant = int_req;
            g.ext_grant = ext_req & ~int_req;
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : gb_bank_ram
//  Description : Simple dual-port read-first RAM, one-cycle registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_bank_ram #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ROW_W  = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ROW_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ROW_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned c_DEPTH = 1 << ROW_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Non-blocking read of r_mem sees the pre-write contents: read-first.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/gb_banked_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : gb_banked_buffer
//  Description : Multi-bank global buffer with per-bank arbitration between
//                the external BRAM-controller port and the internal port.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_banked_buffer
    import gb_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned EXT_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_gb_bramctl_en,
    input  logic              i_gb_bramctl_we,
    input  logic [ADDR_W-1:0] i_gb_bramctl_addr,
    input  logic [DATA_W-1:0] i_gb_bramctl_wdata,
    output logic              o_gb_bramctl_rdy,
    output logic [DATA_W-1:0] o_gb_bramctl_data,
    output logic              o_gb_bramctl_vld,
    input  logic              i_gb_rd_en,
    input  logic              i_gb_pad_en,
    input  logic [ADDR_W-1:0] i_gb_raddr,
    output logic              o_gb_rd_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_vld,
    input  logic              i_gb_wr_en,
    input  logic [ADDR_W-1:0] i_gb_waddr,
    input  logic [DATA_W-1:0] i_gb_wdata,
    output logic              o_gb_wr_rdy
);

    localparam int unsigned c_BSW      = bank_sel_w(NUM_BANKS);
    localparam int unsigned c_BSW_W    = (c_BSW > 0) ? c_BSW : 1;
    localparam int unsigned c_ROW_W    = ADDR_W - c_BSW;
    localparam logic        c_EXT_PRIO = (EXT_PRIO != 0) ? c_PRIO_EXT : c_PRIO_INT;

    // Requests are masked during reset so no handshake or RAM write completes.
    logic w_ext_rd, w_ext_wr, w_int_rd, w_int_pad, w_int_wr;

    assign w_ext_rd  = i_gb_bramctl_en & ~i_gb_bramctl_we & ~rst;
    assign w_ext_wr  = i_gb_bramctl_en &  i_gb_bramctl_we & ~rst;
    assign w_int_pad = i_gb_pad_en & ~rst;
    assign w_int_rd  = i_gb_rd_en & ~i_gb_pad_en & ~rst;
    assign w_int_wr  = i_gb_wr_en & ~rst;

    logic [c_BSW_W-1:0] w_ext_bank, w_int_rbank, w_int_wbank;
    logic [c_ROW_W-1:0] w_ext_row, w_int_rrow, w_int_wrow;

    assign w_ext_row  = i_gb_bramctl_addr[ADDR_W-1:c_BSW];
    assign w_int_rrow = i_gb_raddr[ADDR_W-1:c_BSW];
    assign w_int_wrow = i_gb_waddr[ADDR_W-1:c_BSW];

    generate
        if (c_BSW > 0) begin : g_banked
            assign w_ext_bank  = i_gb_bramctl_addr[c_BSW-1:0];
            assign w_int_rbank = i_gb_raddr[c_BSW-1:0];
            assign w_int_wbank = i_gb_waddr[c_BSW-1:0];
        end else begin : g_single
            assign w_ext_bank  = '0;
            assign w_int_rbank = '0;
            assign w_int_wbank = '0;
        end
    endgenerate

    gb_grant_t [NUM_BANKS-1:0] w_wr_gnt;
    gb_grant_t [NUM_BANKS-1:0] w_rd_gnt;
    logic      [NUM_BANKS-1:0] w_ext_wr_gnt, w_int_wr_gnt;
    logic      [NUM_BANKS-1:0] w_ext_rd_gnt, w_int_rd_gnt;
    logic      [DATA_W-1:0]    w_bank_rdata [NUM_BANKS];

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic w_ext_wr_req, w_int_wr_req, w_ext_rd_req, w_int_rd_req;

            assign w_ext_wr_req = w_ext_wr & (w_ext_bank  == c_BSW_W'(b));
            assign w_int_wr_req = w_int_wr & (w_int_wbank == c_BSW_W'(b));
            assign w_ext_rd_req = w_ext_rd & (w_ext_bank  == c_BSW_W'(b));
            assign w_int_rd_req = w_int_rd & (w_int_rbank == c_BSW_W'(b));

            assign w_wr_gnt[b] = arbitrate(w_ext_wr_req, w_int_wr_req, c_EXT_PRIO);
            assign w_rd_gnt[b] = arbitrate(w_ext_rd_req, w_int_rd_req, c_EXT_PRIO);

            assign w_ext_wr_gnt[b] = w_wr_gnt[b].ext_grant;
            assign w_int_wr_gnt[b] = w_wr_gnt[b].int_grant;
            assign w_ext_rd_gnt[b] = w_rd_gnt[b].ext_grant;
            assign w_int_rd_gnt[b] = w_rd_gnt[b].int_grant;

            gb_bank_ram #(
                .DATA_W (DATA_W),
                .ROW_W  (c_ROW_W)
            ) u_ram (
                .clk     (clk),
                .i_we    (w_ext_wr_gnt[b] | w_int_wr_gnt[b]),
                .i_waddr (w_ext_wr_gnt[b] ? w_ext_row : w_int_wrow),
                .i_wdata (w_ext_wr_gnt[b] ? i_gb_bramctl_wdata : i_gb_wdata),
                .i_re    (w_ext_rd_gnt[b] | w_int_rd_gnt[b]),
                .i_raddr (w_ext_rd_gnt[b] ? w_ext_row : w_int_rrow),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    assign o_gb_bramctl_rdy = (|w_ext_wr_gnt) | (|w_ext_rd_gnt);
    assign o_gb_rd_rdy      = w_int_pad | (|w_int_rd_gnt);
    assign o_gb_wr_rdy      = |w_int_wr_gnt;

    logic                 r_ext_vld, r_int_vld, r_int_pad;
    logic [NUM_BANKS-1:0] r_ext_sel, r_int_sel;
    logic [DATA_W-1:0]    r_ext_hold, r_int_hold;
    logic [DATA_W-1:0]    w_ext_rdata, w_int_rdata;

    // One-hot bank select of the read issued last cycle steers the RAM output.
    always_comb begin
        w_ext_rdata = '0;
        w_int_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_ext_sel[b]) begin
                w_ext_rdata = w_bank_rdata[b];
            end
            if (r_int_sel[b] && !r_int_pad) begin
                w_int_rdata = w_bank_rdata[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_vld  <= 1'b0;
            r_ext_sel  <= '0;
            r_int_vld  <= 1'b0;
            r_int_pad  <= 1'b0;
            r_int_sel  <= '0;
            r_ext_hold <= '0;
            r_int_hold <= '0;
        end else begin
            r_ext_vld <= |w_ext_rd_gnt;
            r_ext_sel <= w_ext_rd_gnt;
            r_int_vld <= o_gb_rd_rdy;
            r_int_pad <= w_int_pad;
            r_int_sel <= w_int_rd_gnt;
            if (r_ext_vld) begin
                r_ext_hold <= w_ext_rdata;
            end
            if (r_int_vld) begin
                r_int_hold <= w_int_rdata;
            end
        end
    end

    assign o_gb_bramctl_vld  = r_ext_vld;
    assign o_gb_bramctl_data = r_ext_vld ? w_ext_rdata : r_ext_hold;
    assign o_data_vld        = r_int_vld;
    assign o_data            = r_int_vld ? w_int_rdata : r_int_hold;

endmodule
`default_nettype wire

// File: tb/tb_gb_banked_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_banked_buffer
//  Description : Self-checking bench for gb_banked_buffer (4 banks, internal
//                priority) with a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_banked_buffer;

    localparam int DW = 256;
    localparam int AW = 13;
    localparam int NB = 4;

    localparam logic [DW-1:0] c_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] c_55 = {32{8'h55}};
    localparam logic [DW-1:0] c_C4 = {32{8'hC4}};
    localparam logic [DW-1:0] c_C8 = {32{8'hC8}};
    localparam logic [DW-1:0] c_D1 = {32{8'hD1}};
    localparam logic [DW-1:0] c_D2 = {32{8'hD2}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_gb_bramctl_en, i_gb_bramctl_we;
    logic [AW-1:0] i_gb_bramctl_addr;
    logic [DW-1:0] i_gb_bramctl_wdata;
    logic          o_gb_bramctl_rdy, o_gb_bramctl_vld;
    logic [DW-1:0] o_gb_bramctl_data;
    logic          i_gb_rd_en, i_gb_pad_en;
    logic [AW-1:0] i_gb_raddr;
    logic          o_gb_rd_rdy, o_data_vld;
    logic [DW-1:0] o_data;
    logic          i_gb_wr_en;
    logic [AW-1:0] i_gb_waddr;
    logic [DW-1:0] i_gb_wdata;
    logic          o_gb_wr_rdy;

    int checks = 0;
    int errors = 0;

    gb_banked_buffer #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_BANKS (NB),
        .EXT_PRIO  (0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_gb_bramctl_en    (i_gb_bramctl_en),
        .i_gb_bramctl_we    (i_gb_bramctl_we),
        .i_gb_bramctl_addr  (i_gb_bramctl_addr),
        .i_gb_bramctl_wdata (i_gb_bramctl_wdata),
        .o_gb_bramctl_rdy   (o_gb_bramctl_rdy),
        .o_gb_bramctl_data  (o_gb_bramctl_data),
        .o_gb_bramctl_vld   (o_gb_bramctl_vld),
        .i_gb_rd_en         (i_gb_rd_en),
        .i_gb_pad_en        (i_gb_pad_en),
        .i_gb_raddr         (i_gb_raddr),
        .o_gb_rd_rdy        (o_gb_rd_rdy),
        .o_data             (o_data),
        .o_data_vld         (o_data_vld),
        .i_gb_wr_en         (i_gb_wr_en),
        .i_gb_waddr         (i_gb_waddr),
        .i_gb_wdata         (i_gb_wdata),
        .o_gb_wr_rdy        (o_gb_wr_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic bit same_bank(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (int'(a) % NB) == (int'(b) % NB);
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    // Reference model: stimulus is confined to a 64-word window.
    logic [DW-1:0] mdl_mem [64];
    logic          mdl_ext_vld = 1'b0, mdl_int_vld = 1'b0;
    logic [DW-1:0] mdl_ext_data = '0, mdl_int_data = '0;
    bit            armed = 1'b0;
    bit            e_rdy, r_rdy, w_rdy;

    always @(negedge clk) begin
        if (rst) begin
            e_rdy = 1'b0;
            r_rdy = 1'b0;
            w_rdy = 1'b0;
        end else begin
            w_rdy = i_gb_wr_en;
            r_rdy = i_gb_pad_en || i_gb_rd_en;
            if (!i_gb_bramctl_en)
                e_rdy = 1'b0;
            else if (i_gb_bramctl_we)
                e_rdy = !(i_gb_wr_en && same_bank(i_gb_bramctl_addr, i_gb_waddr));
            else
                e_rdy = !(i_gb_rd_en && !i_gb_pad_en && same_bank(i_gb_bramctl_addr, i_gb_raddr));
        end
        check_bit("mdl_ext_rdy", o_gb_bramctl_rdy, e_rdy);
        check_bit("mdl_rd_rdy", o_gb_rd_rdy, r_rdy);
        check_bit("mdl_wr_rdy", o_gb_wr_rdy, w_rdy);
        if (armed) begin
            check_bit("mdl_ext_vld", o_gb_bramctl_vld, mdl_ext_vld);
            check("mdl_ext_data", o_gb_bramctl_data, mdl_ext_data);
            check_bit("mdl_int_vld", o_data_vld, mdl_int_vld);
            check("mdl_int_data", o_data, mdl_int_data);
        end
        if (rst) begin
            mdl_ext_vld  = 1'b0;
            mdl_int_vld  = 1'b0;
            mdl_ext_data = '0;
            mdl_int_data = '0;
            armed        = 1'b1;
        end else begin
            mdl_ext_vld = e_rdy && !i_gb_bramctl_we;
            if (mdl_ext_vld) mdl_ext_data = mdl_mem[i_gb_bramctl_addr[5:0]];
            mdl_int_vld = r_rdy;
            if (i_gb_pad_en)     mdl_int_data = '0;
            else if (i_gb_rd_en) mdl_int_data = mdl_mem[i_gb_raddr[5:0]];
            if (e_rdy && i_gb_bramctl_we) mdl_mem[i_gb_bramctl_addr[5:0]] = i_gb_bramctl_wdata;
            if (w_rdy) mdl_mem[i_gb_waddr[5:0]] = i_gb_wdata;
        end
    end

    task automatic idle();
        i_gb_bramctl_en = 0; i_gb_bramctl_we = 0; i_gb_bramctl_addr = '0; i_gb_bramctl_wdata = '0;
        i_gb_rd_en = 0; i_gb_pad_en = 0; i_gb_raddr = '0;
        i_gb_wr_en = 0; i_gb_waddr = '0; i_gb_wdata = '0;
    endtask

    task automatic ext_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_gb_bramctl_en = 1; i_gb_bramctl_we = we; i_gb_bramctl_addr = a; i_gb_bramctl_wdata = d;
    endtask

    task automatic int_rd(input logic pad, input logic rd, input logic [AW-1:0] a);
        i_gb_pad_en = pad; i_gb_rd_en = rd; i_gb_raddr = a;
    endtask

    task automatic int_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_gb_wr_en = 1; i_gb_waddr = a; i_gb_wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    bit ea, ra, wa;

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        check_bit("reset_ext_vld", o_gb_bramctl_vld, 1'b0);
        check_bit("reset_int_vld", o_data_vld, 1'b0);
        check("reset_ext_data", o_gb_bramctl_data, '0);
        check("reset_int_data", o_data, '0);
        check_bit("reset_ext_rdy", o_gb_bramctl_rdy, 1'b0);
        check_bit("reset_rd_rdy", o_gb_rd_rdy, 1'b0);

        // Fill the window: ext and int writes to adjacent (different-bank) words.
        for (int a = 0; a < 64; a += 2) begin
            step(); idle();
            ext_req(1'b1, AW'(a), rnd_word());
            int_wr(AW'(a + 1), rnd_word());
        end

        // Write/read round trip
        step(); idle(); ext_req(1'b1, 13'h10, c_A5);
        @(negedge clk); check_bit("rt_wr_rdy", o_gb_bramctl_rdy, 1'b1);
        step(); idle(); int_rd(1'b0, 1'b1, 13'h10);
        @(negedge clk); check_bit("rt_rd_rdy", o_gb_rd_rdy, 1'b1);
        step(); idle();
        @(negedge clk); check("rt_data", o_data, c_A5); check_bit("rt_vld", o_data_vld, 1'b1);
        step();
        @(negedge clk); check_bit("rt_vld_pulse", o_data_vld, 1'b0); check("rt_hold", o_data, c_A5);

        // Same-bank write conflict: internal wins, external held
        step(); idle(); ext_req(1'b1, 13'h04, c_C4); int_wr(13'h08, c_C8);
        @(negedge clk); check_bit("wc_ext_rdy", o_gb_bramctl_rdy, 1'b0); check_bit("wc_int_rdy", o_gb_wr_rdy, 1'b1);
        step(); i_gb_wr_en = 0;
        @(negedge clk); check_bit("wc_ext_retry", o_gb_bramctl_rdy, 1'b1);

        // Same-bank read conflict
        step(); idle(); ext_req(1'b0, 13'h04, '0); int_rd(1'b0, 1'b1, 13'h08);
        @(negedge clk); check_bit("rc_ext_rdy", o_gb_bramctl_rdy, 1'b0); check_bit("rc_int_rdy", o_gb_rd_rdy, 1'b1);
        step(); int_rd(1'b0, 1'b0, '0);
        @(negedge clk); check_bit("rc_ext_retry", o_gb_bramctl_rdy, 1'b1);
        check("rc_int_data", o_data, c_C8); check_bit("rc_ext_vld0", o_gb_bramctl_vld, 1'b0);
        step(); idle();
        @(negedge clk); check_bit("rc_ext_vld", o_gb_bramctl_vld, 1'b1); check("rc_ext_data", o_gb_bramctl_data, c_C4);

        // Different-bank concurrency
        step(); idle(); ext_req(1'b1, 13'h01, c_D1); int_wr(13'h02, c_D2);
        @(negedge clk); check_bit("db_ext_rdy", o_gb_bramctl_rdy, 1'b1); check_bit("db_int_rdy", o_gb_wr_rdy, 1'b1);
        step(); idle(); ext_req(1'b0, 13'h02, '0); int_rd(1'b0, 1'b1, 13'h01);
        @(negedge clk); check_bit("db_ext_rrdy", o_gb_bramctl_rdy, 1'b1); check_bit("db_int_rrdy", o_gb_rd_rdy, 1'b1);
        step(); idle();
        @(negedge clk); check("db_ext_data", o_gb_bramctl_data, c_D2); check("db_int_data", o_data, c_D1);

        // Pad takes precedence over rd_en; ext read proceeds
        step(); idle(); int_rd(1'b1, 1'b1, 13'h10); ext_req(1'b0, 13'h01, '0);
        @(negedge clk); check_bit("pad_rdy", o_gb_rd_rdy, 1'b1); check_bit("pad_ext_rdy", o_gb_bramctl_rdy, 1'b1);
        step(); idle();
        @(negedge clk); check("pad_data", o_data, '0); check_bit("pad_vld", o_data_vld, 1'b1);
        check("pad_ext_data", o_gb_bramctl_data, c_D1);

        // Read-during-write returns old data
        step(); idle(); ext_req(1'b1, 13'h10, c_55); int_rd(1'b0, 1'b1, 13'h10);
        @(negedge clk); check_bit("rdw_wr_rdy", o_gb_bramctl_rdy, 1'b1); check_bit("rdw_rd_rdy", o_gb_rd_rdy, 1'b1);
        step(); idle(); int_rd(1'b0, 1'b1, 13'h10);
        @(negedge clk); check("rdw_old", o_data, c_A5);
        step(); idle();
        @(negedge clk); check("rdw_new", o_data, c_55);

        // Randomised traffic; a requester holds until accepted
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            ea = i_gb_bramctl_en && o_gb_bramctl_rdy;
            ra = (i_gb_rd_en || i_gb_pad_en) && o_gb_rd_rdy;
            wa = i_gb_wr_en && o_gb_wr_rdy;
            step();
            if (!i_gb_bramctl_en || ea) begin
                if ($urandom_range(9) < 7) ext_req(1'($urandom_range(1)), AW'($urandom_range(63)), rnd_word());
                else i_gb_bramctl_en = 0;
            end
            if (!(i_gb_rd_en || i_gb_pad_en) || ra) begin
                int_rd(($urandom_range(9) < 2), ($urandom_range(9) < 6), AW'($urandom_range(63)));
            end
            if (!i_gb_wr_en || wa) begin
                if ($urandom_range(1) == 1) int_wr(AW'($urandom_range(63)), rnd_word());
                else i_gb_wr_en = 0;
            end
        end

        // Reset in the middle of a read burst
        step(); idle(); int_rd(1'b0, 1'b1, 13'h03);
        step(); int_rd(1'b0, 1'b1, 13'h05);
        step(); rst = 1;
        @(negedge clk); check_bit("rst_rd_rdy", o_gb_rd_rdy, 1'b0);
        step(); rst = 0; idle();
        @(negedge clk); check_bit("rst_vld", o_data_vld, 1'b0); check("rst_data", o_data, '0);
        repeat (3) step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
